// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter in front of a shared combinational ALU, with starvation guard and registered response.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [4:0]      req0_shamt,
  input  logic [4:0]      req0_ctl,
  input  logic [6:0]      req0_funct7,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [4:0]      req1_shamt,
  input  logic [4:0]      req1_ctl,
  input  logic [6:0]      req1_funct7,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_shamt,
  output logic [4:0]      alu_ctl,
  output logic [6:0]      alu_funct7,
  input  logic [XLEN-1:0] alu_out
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          op_id, accept, grant1, take;
  // rst gates accept so neither ready is raised while reset is held
  assign accept = !rst && (state == IDLE || (state == HOLD && rsp_valid && rsp_ready));
  assign grant1 = req1_valid && (!req0_valid || cnt == SMAX);
  assign req0_ready = accept && req0_valid && !grant1;
  assign req1_ready = accept && grant1;
  assign take = accept && (req0_valid || req1_valid);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_id <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_shamt <= '0;
      alu_ctl <= '0;
      alu_funct7 <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (accept) cnt <= (req0_valid && req1_valid && !grant1) ? (cnt == SMAX ? cnt : cnt + 1'b1) : '0;
      if (take) begin
        alu_a <= grant1 ? req1_a : req0_a;
        alu_b <= grant1 ? req1_b : req0_b;
        alu_shamt <= grant1 ? req1_shamt : req0_shamt;
        alu_ctl <= grant1 ? req1_ctl : req0_ctl;
        alu_funct7 <= grant1 ? req1_funct7 : req0_funct7;
        op_id <= grant1;
      end
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_id <= op_id;
        rsp_valid <= 1'b1;
      end else if (accept) rsp_valid <= 1'b0;
      state <= take ? EXEC : state == EXEC ? HOLD : (state == HOLD && !accept) ? HOLD : IDLE;
    end
  end
endmodule
